// File: rtl/decode_stage_rf.sv
// RV32I decode stage: field extraction, register-file operand read, immediate generation, illegal flagging.
// Latency: 1 cycle from accept to out_valid; regfile writes land on the same edge.
// Backpressure: in_ready = !out_valid || out_ready; held operands refresh from writeback while stalled.
module decode_stage_rf #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Always 32 entries; entries at or above REG_COUNT are never written and read as zero.
    logic [XLEN-1:0] regs [32];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [31:0]     imm32;
    logic            legal_op;
    logic            illegal;
    logic            wb_hit;
    logic            accept;
    logic            hold;
    logic [XLEN-1:0] rs1_val, rs2_val;

    function automatic logic in_range(input logic [4:0] idx);
        return 32'(idx) < 32'(REG_COUNT);
    endfunction

    // Stored value, with optional same-cycle forwarding of the writeback data.
    function automatic logic [XLEN-1:0] read_op(input logic [4:0] idx);
        if (idx == 5'd0 || !in_range(idx))
            return '0;
        if (BYPASS_EN && wb_hit && wb_addr == idx)
            return wb_data;
        return regs[idx];
    endfunction

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign wb_hit   = wb_en && wb_addr != 5'd0 && in_range(wb_addr);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign hold     = out_valid && !out_ready;
    assign rs1_val  = read_op(rs1);
    assign rs2_val  = read_op(rs2);

    // Immediate selection by format; unknown opcodes leave legal_op low.
    always_comb begin
        imm32    = '0;
        legal_op = 1'b1;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            OP_STORE:  imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OP_BRANCH: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm32 = {in_instr[31:12], 12'b0};
            OP_JAL:    imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            OP_OP, OP_SYSTEM: imm32 = '0;
            default:   legal_op = 1'b0;
        endcase
    end

    assign illegal = !legal_op || in_instr[1:0] != 2'b11 ||
                     !in_range(rd) || !in_range(rs1) || !in_range(rs2);

    // Register file: async clear, writes to x0 or out-of-range indices dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pipeline register: flush beats accept beats clear/hold; held operands track writeback.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7   <= '0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_opcode   <= opcode;
            out_funct3   <= in_instr[14:12];
            out_funct7   <= in_instr[31:25];
            out_rd       <= rd;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_rs1_data <= rs1_val;
            out_rs2_data <= rs2_val;
            out_imm      <= illegal ? '0 : XLEN'($signed(imm32));
            out_illegal  <= illegal;
        end else if (hold) begin
            if (wb_hit && wb_addr == out_rs1) out_rs1_data <= wb_data;
            if (wb_hit && wb_addr == out_rs2) out_rs2_data <= wb_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage_rf.sv
// Drives three decode stages (default, no-bypass, 16-register) with shared stimulus.
// Behavioural model is updated on each rising edge; outputs are compared on falling edges.
// Directed literal checks pin the model, followed by a randomized phase.
module tb_decode_stage_rf;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        ill;
    } bun_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    int          lit_tag = 0;

    bun_t [2:0]  dbun;
    logic [2:0]  dvld;
    logic [2:0]  drdy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int rc_of(input int k);
        return (k == 2) ? 16 : 32;
    endfunction

    function automatic bit bp_of(input int k);
        return (k == 1) ? 1'b0 : 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] pc, d1, d2, imm;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic        ill, vld, rdy;
        decode_stage_rf #(.XLEN(32), .REG_COUNT(g == 2 ? 16 : 32), .BYPASS_EN(g == 1 ? 1'b0 : 1'b1)) u_dut (
            .clk(clk), .reset(rst_n), .in_valid(in_valid), .in_ready(rdy),
            .in_instr(in_instr), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
            .wb_data(wb_data), .flush(flush), .out_valid(vld), .out_ready(out_ready),
            .out_pc(pc), .out_opcode(op), .out_funct3(f3), .out_funct7(f7),
            .out_rd(rd), .out_rs1(rs1), .out_rs2(rs2), .out_rs1_data(d1),
            .out_rs2_data(d2), .out_imm(imm), .out_illegal(ill)
        );
        assign dbun[g] = {pc, op, f3, f7, rd, rs1, rs2, d1, d2, imm, ill};
        assign dvld[g] = vld;
        assign drdy[g] = rdy;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] mregs [3][32];
    bun_t        mb [3];
    logic        mv [3];

    function automatic bit legal_opc(input logic [6:0] op);
        return op inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};
    endfunction

    // Immediate as an arithmetic value: signed shifts supply the sign extension.
    function automatic logic [31:0] imm_of(input logic [31:0] i);
        logic [31:0] sgn;
        sgn = 32'($signed(i) >>> 31);
        case (i[6:0])
            7'h13, 7'h03, 7'h67: return 32'($signed(i) >>> 20);
            7'h23: return (32'($signed(i) >>> 20) & 32'hFFFF_FFE0) | 32'(i[11:7]);
            7'h63: return (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
            7'h37, 7'h17: return i & 32'hFFFF_F000;
            7'h6F: return (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit qual(input int k);
        return wb_en && wb_addr != 0 && int'(wb_addr) < rc_of(k);
    endfunction

    function automatic logic [31:0] rdreg(input int k, input logic [4:0] idx);
        if (idx == 0 || int'(idx) >= rc_of(k)) return 32'd0;
        if (bp_of(k) && qual(k) && wb_addr == idx) return wb_data;
        return mregs[k][idx];
    endfunction

    function automatic bun_t load(input int k);
        bun_t b;
        b.pc  = in_pc;
        b.op  = in_instr[6:0];
        b.f3  = in_instr[14:12];
        b.f7  = in_instr[31:25];
        b.rd  = in_instr[11:7];
        b.rs1 = in_instr[19:15];
        b.rs2 = in_instr[24:20];
        b.d1  = rdreg(k, b.rs1);
        b.d2  = rdreg(k, b.rs2);
        b.ill = !legal_opc(b.op) || int'(b.rd) >= rc_of(k) ||
                int'(b.rs1) >= rc_of(k) || int'(b.rs2) >= rc_of(k);
        b.imm = b.ill ? 32'd0 : imm_of(in_instr);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mv[k] <= 1'b0;
                mb[k] <= '0;
                for (int r = 0; r < 32; r++) mregs[k][r] <= 32'd0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (flush) mv[k] <= 1'b0;
                else if (in_valid && (!mv[k] || out_ready)) begin
                    mv[k] <= 1'b1;
                    mb[k] <= load(k);
                end else if (mv[k] && out_ready) mv[k] <= 1'b0;
                else if (mv[k]) begin
                    if (qual(k) && wb_addr == mb[k].rs1) mb[k].d1 <= wb_data;
                    if (qual(k) && wb_addr == mb[k].rs2) mb[k].d2 <= wb_data;
                end
                if (qual(k)) mregs[k][wb_addr] <= wb_data;
            end
        end
    end

    // ---------------- compare process ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k), 32'(drdy[k]), 32'(!mv[k] || out_ready));
            chk($sformatf("out_valid[%0d]", k), 32'(dvld[k]), 32'(mv[k]));
            if (mv[k] || !rst_n) begin
                tests++;
                if (dbun[k] !== mb[k]) begin
                    fails++;
                    $display("FAIL bundle[%0d]: got %h expected %h", k, dbun[k], mb[k]);
                end
            end
        end
        case (lit_tag)
            1: begin
                chk("rst_valid", 32'(dvld[0]), 32'd0);
                chk("rst_pc", dbun[0].pc, 32'd0);
                chk("rst_imm", dbun[0].imm, 32'd0);
                chk("rst_ready", 32'(drdy[0]), 32'd1);
            end
            2: begin
                chk("addi_valid", 32'(dvld[0]), 32'd1);
                chk("addi_rs1", dbun[0].d1, 32'h0000_1234);
                chk("addi_imm", dbun[0].imm, 32'hFFFF_FFFF);
                chk("addi_rd", 32'(dbun[0].rd), 32'd6);
            end
            3: begin
                chk("byp_rs1", dbun[0].d1, 32'hA5A5_0000);
                chk("byp_rs2", dbun[0].d2, 32'hA5A5_0000);
                chk("nobyp_rs1", dbun[1].d1, 32'h0000_1234);
                chk("nobyp_rs2", dbun[1].d2, 32'h0000_1234);
            end
            4: begin
                chk("hold_ready", 32'(drdy[0]), 32'd0);
                chk("hold_rd", 32'(dbun[0].rd), 32'd6);
                chk("hold_valid", 32'(dvld[0]), 32'd1);
            end
            5: begin
                chk("refresh_rs1", dbun[0].d1, 32'h0000_0055);
                chk("refresh_ready", 32'(drdy[0]), 32'd0);
                chk("refresh_rd", 32'(dbun[0].rd), 32'd6);
            end
            16: begin
                chk("hold3_rs1", dbun[0].d1, 32'h0000_0055);
                chk("hold3_imm", dbun[0].imm, 32'hFFFF_FFFF);
            end
            6: begin
                chk("x0_rs1", dbun[0].d1, 32'd0);
                chk("x0_rs2", dbun[0].d2, 32'd0);
                chk("x0_rd", 32'(dbun[0].rd), 32'd1);
            end
            7: chk("flush_valid", 32'(dvld[0]), 32'd0);
            8: chk("beq_imm", dbun[0].imm, 32'hFFFF_FFFC);
            9: chk("jal_imm", dbun[0].imm, 32'd8);
            10: chk("lui_imm", dbun[0].imm, 32'h1234_5000);
            11: begin
                chk("bad_ill", 32'(dbun[0].ill), 32'd1);
                chk("bad_imm", dbun[0].imm, 32'd0);
            end
            12: begin
                chk("rc16_ill", 32'(dbun[2].ill), 32'd1);
                chk("rc32_ill", 32'(dbun[0].ill), 32'd0);
            end
            13: begin
                chk("arst_valid", 32'(dvld[0]), 32'd0);
                chk("arst_rs1", dbun[0].d1, 32'd0);
                chk("arst_pc", dbun[0].pc, 32'd0);
                chk("arst_valid16", 32'(dvld[2]), 32'd0);
            end
            14: begin
                chk("postrst_rs1", dbun[0].d1, 32'd0);
                chk("postrst_valid", 32'(dvld[0]), 32'd1);
            end
            default: ;
        endcase
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] ADDI6 = 32'hFFF2_8313;
    localparam logic [31:0] ADD7  = 32'h0052_83B3;
    localparam logic [31:0] ADD1  = 32'h0000_00B3;
    localparam logic [31:0] LUI_I = 32'h1234_5037;

    task automatic drive(input logic v, input logic [31:0] instr, input logic rdy,
                         input logic fl, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = $urandom();
        out_ready = rdy;
        flush     = fl;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
    endtask

    task automatic tick(input int tag);
        @(posedge clk);
        #2;
        lit_tag = tag;
    endtask

    logic [6:0] ops [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73};

    initial begin
        logic [31:0] r, ins;
        logic [4:0]  wa;
        drive(0, 0, 1, 0, 0, 0, 0);
        tick(0);
        tick(1);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 1, 5'd5, 32'h0000_1234);            tick(0);
        drive(1, ADDI6, 1, 0, 0, 0, 0);                       tick(2);
        drive(1, ADD7, 1, 0, 1, 5'd5, 32'hA5A5_0000);         tick(3);
        drive(1, ADDI6, 1, 0, 0, 0, 0);                       tick(0);
        drive(1, LUI_I, 0, 0, 0, 0, 0);                       tick(4);
        drive(1, LUI_I, 0, 0, 1, 5'd5, 32'h0000_0055);        tick(5);
        drive(1, LUI_I, 0, 0, 0, 0, 0);                       tick(16);
        drive(0, 0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);            tick(0);
        drive(1, ADD1, 1, 0, 0, 0, 0);                        tick(6);
        drive(1, ADD7, 1, 1, 0, 0, 0);                        tick(7);
        drive(1, 32'hFE00_0EE3, 1, 0, 0, 0, 0);               tick(8);
        drive(1, 32'h0080_006F, 1, 0, 0, 0, 0);               tick(9);
        drive(1, LUI_I, 1, 0, 0, 0, 0);                       tick(10);
        drive(1, 32'h0000_007F, 1, 0, 0, 0, 0);               tick(11);
        drive(1, 32'h0020_8A33, 1, 0, 0, 0, 0);               tick(12);
        drive(1, ADD7, 1, 0, 0, 0, 0);                        tick(0);
        drive(0, 0, 0, 0, 0, 0, 0);                           tick(0);
        lit_tag = 13;
        rst_n = 1'b0;
        tick(0);
        tick(0);
        rst_n = 1'b1;
        drive(1, ADD7, 1, 0, 0, 0, 0);                        tick(14);
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom();
            wa  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ins = ($urandom_range(0, 9) < 9) ? {r[31:7], ops[$urandom_range(0, 9)]} : $urandom();
            if ($urandom_range(0, 1) == 0) ins[19:15] = wa;
            if ($urandom_range(0, 2) == 0) ins[24:20] = wa;
            drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, wa, $urandom());
            tick(0);
        end
        drive(0, 0, 1, 0, 0, 0, 0);
        tick(0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
